fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 16-bit MISC-V pipeline. Drives the instruction-memory request handshake and keeps the fetch PC. Loads the IF/ID pipeline register that feeds `pc_in`, `ir_in` and `IPCP2` to the decode stage. Consumes decode's `jump`/`new_pc` redirect and the hazard `stall`, and buffers one in-flight response so a stall never loses an instruction.

## Interface
- `RESET_PC`, default 16'h0000, first fetch address after reset.
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold IF/ID contents (decode hazard).
- `jump`  in  1  redirect request from decode.
- `new_pc`  in  16  redirect target, valid when `jump`=1.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  16  fetch address.
- `imem_ready`  in  1  memory accepts request when `imem_req`&`imem_ready`.
- `imem_rvalid`  in  1  read data valid; at most one per accepted request, any later cycle.
- `imem_rdata`  in  16  instruction word.
- `pc_out`  out  16  IF/ID PC (to decode `pc_in`).
- `ir_out`  out  16  IF/ID instruction (to decode `ir_in`).
- `IPCP2`  out  16  IF/ID PC+2.
- `if_valid`  out  1  IF/ID holds a real instruction.

## Operation
- State registers: `fetch_pc`, `req_pc`, FSM {IDLE, WAIT, DRAIN}, hold buffer {`hold_valid`, `hold_pc`, `hold_ir`}. At most one request outstanding.
- `adv` = !`stall` | !`if_valid`.
- `imem_req` is asserted in two cases; in both, `imem_addr` = `fetch_pc`:
  - IDLE & !`hold_valid` & !`jump`.
  - WAIT & `imem_rvalid` & `adv` & !`hold_valid` & !`jump`. This is the back-to-back case. The combinational path `imem_rvalid`→`imem_req` is intended.
- Request accepted (`imem_req`&`imem_ready`): `req_pc`←`fetch_pc`; `fetch_pc`←`fetch_pc`+2 (mod 2^16, 16'hFFFE wraps to 0); state→WAIT. While `imem_ready`=0, `imem_addr` is held stable.
- WAIT & `imem_rvalid` & !`jump`:
  - If `adv`: IF/ID←{`req_pc`, `imem_rdata`, `req_pc`+2}, `if_valid`←1.
  - Otherwise: hold buffer←{`req_pc`, `imem_rdata`}, `hold_valid`←1.
  - State→WAIT if a new request was accepted the same cycle, else IDLE.
- `hold_valid` & `adv` & !`jump`: IF/ID←hold buffer, `if_valid`←1, `hold_valid`←0.
- `adv` with no response and no hold data: `if_valid`←0 (bubble). !`adv`: IF/ID unchanged.
- `jump`=1 (priority over `stall`, responses and hold):
  - `fetch_pc`←`new_pc`, `if_valid`←0, `hold_valid`←0, `imem_req`=0.
  - WAIT without `imem_rvalid` → DRAIN. WAIT with `imem_rvalid` → the data is discarded, state → IDLE.
- DRAIN: `imem_req`=0. The next `imem_rvalid` is discarded and state → IDLE. A `jump` in DRAIN updates `fetch_pc` and stays in DRAIN.
- `new_pc[0]` is used as given; no alignment check.
- `imem_rvalid` in IDLE is a protocol violation and is ignored.

## Timing
- Reset values: `fetch_pc`=`RESET_PC`, state IDLE, `hold_valid`=0, `pc_out`=0, `ir_out`=0, `IPCP2`=0, `if_valid`=0.
- Outputs while `reset` is asserted: `imem_req`=0, `imem_addr`=`RESET_PC`.
- Reset mid-WAIT or mid-DRAIN abandons the outstanding response. Memory is reset by the same signal.
- First request is asserted in the first cycle after `reset` deasserts.
- Latency: request accepted in cycle N with `imem_rvalid` in N+k → `if_valid`=1 from the edge ending N+k (when `adv`).
- With `imem_ready`=1 and 1-cycle read latency, throughput is one instruction per cycle.
- Stall release drains the hold buffer first, then resumes streaming. No instruction is lost or duplicated.
- Redirect: first request to `new_pc` is asserted the cycle after `jump`, or the cycle after the discarded response when in DRAIN.

## Test plan
- Reset, `RESET_PC`=0: all outputs at reset values, `imem_req`=0. First cycle after release: `imem_req`=1, `imem_addr`=0.
- Zero-wait memory (ready=1, rvalid next cycle, rdata=addr^16'hA5A5): IF/ID shows pc 0,2,4,6 on consecutive cycles. `IPCP2`=pc+2, `if_valid`=1 throughout.
- `stall` for 3 cycles while a response is in flight:
  - IF/ID holds pc 2 and the hold buffer captures pc 4.
  - No request is issued while `hold_valid`=1.
  - After release, IF/ID shows pc 4 then pc 6, with no gap beyond one cycle.
- `jump` with `new_pc`=16'h0040 while in WAIT, rvalid arriving 2 cycles later:
  - `if_valid`=0 the next cycle and the late data is discarded.
  - Next `imem_addr`=16'h0040 and IF/ID then shows pc 16'h0040.
- `jump` and `stall` in the same cycle with a response arriving: the response is discarded, `if_valid`=0, and the fetch resumes at `new_pc`.
- Wrap: `RESET_PC`=16'hFFFE → fetch addresses 16'hFFFE, 16'h0000. `IPCP2` for the first instruction is 16'h0000.
- `imem_ready` low for 4 cycles: `imem_addr` stable. Reset asserted mid-WAIT: outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage for the 16-bit MISC-V pipeline: fetch PC, imem request
// handshake, IF/ID register and a one-entry hold buffer so stalls never drop a response.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump,
  input  logic [15:0] new_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic [15:0] pc_out,
  output logic [15:0] ir_out,
  output logic [15:0] IPCP2,
  output logic        if_valid
);

  // state | meaning
  // IDLE  | nothing outstanding, free to issue a request
  // WAIT  | one request accepted, response pending
  // DRAIN | response pending but squashed by a redirect; discard it
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DRAIN = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [15:0] fetch_pc, req_pc, hold_pc, hold_ir;
  logic        hold_valid;
  logic        adv, resp, accept;

  assign adv       = !stall || !if_valid;
  assign resp      = (state == WAIT) && imem_rvalid;
  assign accept    = imem_req && imem_ready;
  assign imem_addr = fetch_pc;

  always_comb begin
    imem_req  = 1'b0;
    state_nxt = state;
    // back-to-back issue follows imem_rvalid combinationally to keep one fetch per cycle
    if (reset && !jump && !hold_valid)
      imem_req = (state == IDLE) || (resp && adv);
    case (state)
      IDLE:  if (accept) state_nxt = WAIT;
      WAIT: begin
        if (jump)             state_nxt = imem_rvalid ? IDLE : DRAIN;
        else if (imem_rvalid) state_nxt = accept ? WAIT : IDLE;
      end
      DRAIN: if (imem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (jump)        fetch_pc <= new_pc;
      else if (accept) fetch_pc <= fetch_pc + 16'd2;
      if (accept) req_pc <= fetch_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_out     <= 16'h0000;
      ir_out     <= 16'h0000;
      IPCP2      <= 16'h0000;
      if_valid   <= 1'b0;
      hold_valid <= 1'b0;
      hold_pc    <= 16'h0000;
      hold_ir    <= 16'h0000;
    end else if (jump) begin
      if_valid   <= 1'b0;
      hold_valid <= 1'b0;
    end else if (hold_valid && adv) begin
      pc_out     <= hold_pc;
      ir_out     <= hold_ir;
      IPCP2      <= hold_pc + 16'd2;
      if_valid   <= 1'b1;
      hold_valid <= 1'b0;
    end else if (resp) begin
      if (adv) begin
        pc_out   <= req_pc;
        ir_out   <= imem_rdata;
        IPCP2    <= req_pc + 16'd2;
        if_valid <= 1'b1;
      end else begin
        hold_pc    <= req_pc;
        hold_ir    <= imem_rdata;
        hold_valid <= 1'b1;
      end
    end else if (adv) begin
      if_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table plus scoreboard of fetched instructions,
// with a small memory model of programmable latency/readiness.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, jump, imem_ready, imem_rvalid;
  logic [15:0] new_pc, imem_rdata;
  logic        imem_req, if_valid;
  logic [15:0] imem_addr, pc_out, ir_out, ipcp2;

  logic        w_req, w_rvalid, w_iv;
  logic [15:0] w_addr, w_rdata, w_pc, w_ir, w_ipcp2;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .jump(jump), .new_pc(new_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .ir_out(ir_out), .IPCP2(ipcp2), .if_valid(if_valid)
  );

  fetch_stage #(.RESET_PC(16'hFFFE)) u_wrap (
    .clk(clk), .reset(reset), .stall(1'b0), .jump(1'b0), .new_pc(16'h0000),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(1'b1),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .pc_out(w_pc), .ir_out(w_ir), .IPCP2(w_ipcp2), .if_valid(w_iv)
  );

  typedef struct { logic [15:0] pc; logic [15:0] ir; logic [15:0] pcp2; } exp_t;
  typedef struct {
    logic stall; logic jump; logic [15:0] new_pc;
    logic req; logic [15:0] addr; logic iv; logic chk_pc; logic [15:0] pc;
  } vec_t;

  exp_t        sb_q[$];
  exp_t        last_exp;
  vec_t        tbl[13];
  int          n_cmp = 0, n_bad = 0;
  bit          pend, draining, w_pend;
  int          pend_cnt, mem_lat;
  logic        mem_ready;
  logic [15:0] pend_addr, w_pend_addr, exp_fetch, a0;
  logic        cur_req, cur_w_req;
  logic [15:0] cur_addr, cur_w_addr;

  task automatic chk1(input string nm, input logic act, input logic want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, want);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic clear_model();
    sb_q.delete();
    pend = 0; draining = 0; w_pend = 0; pend_cnt = 0;
    pend_addr = 16'h0; w_pend_addr = 16'h0;
    exp_fetch = 16'h0000;
    last_exp = '{16'h0, 16'h0, 16'h0};
  endtask

  // One clock: drive at the sample point, check combinational outputs, then registered ones.
  task automatic cycle(input logic s, input logic j, input logic [15:0] np);
    logic        iv_before, adv, acc;
    logic [15:0] acc_addr;
    exp_t        e;
    stall = s; jump = j; new_pc = np; imem_ready = mem_ready;
    imem_rvalid = pend && (pend_cnt == 1);
    imem_rdata  = imem_rvalid ? (pend_addr ^ 16'hA5A5) : 16'h0000;
    w_rvalid    = w_pend;
    w_rdata     = w_pend ? (w_pend_addr ^ 16'hA5A5) : 16'h0000;
    #1;
    cur_req = imem_req; cur_addr = imem_addr;
    cur_w_req = w_req;  cur_w_addr = w_addr;
    if (imem_req) chk16("fetch_addr", imem_addr, exp_fetch);
    if (j) chk1("req_on_jump", imem_req, 1'b0);
    acc = imem_req && imem_ready;
    acc_addr = imem_addr;
    iv_before = if_valid;
    adv = !s || !iv_before;
    if (imem_rvalid) begin
      if (j || draining) draining = 0;
      else begin
        e.pc = pend_addr; e.ir = pend_addr ^ 16'hA5A5; e.pcp2 = pend_addr + 16'd2;
        sb_q.push_back(e);
      end
      pend = 0;
    end else if (pend) pend_cnt--;
    if (j) begin
      sb_q.delete();
      if (pend) draining = 1;
      exp_fetch = np;
    end
    if (acc) begin
      pend = 1; pend_cnt = mem_lat; pend_addr = acc_addr;
      exp_fetch = exp_fetch + 16'd2;
    end
    w_pend = w_req; w_pend_addr = w_addr;
    @(posedge clk); #1;
    if (j) chk1("iv_after_jump", if_valid, 1'b0);
    else if (adv) begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk1("iv_load", if_valid, 1'b1);
        chk16("pc_load", pc_out, e.pc);
        chk16("ir_load", ir_out, e.ir);
        chk16("ipcp2_load", ipcp2, e.pcp2);
        last_exp = e;
      end else chk1("iv_bubble", if_valid, 1'b0);
    end else begin
      chk1("iv_hold", if_valid, 1'b1);
      chk16("pc_hold", pc_out, last_exp.pc);
      chk16("ir_hold", ir_out, last_exp.ir);
      chk16("ipcp2_hold", ipcp2, last_exp.pcp2);
    end
  endtask

  initial begin
    //            stall  jump  new_pc    req   addr      iv    chk   pc
    tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b1, 1'b1, 16'h0000};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 1'b1, 16'h0002};
    tbl[3]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002};
    tbl[4]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002};
    tbl[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0004};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b0, 1'b0, 16'h0000};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b1, 1'b1, 16'h0006};
    tbl[9]  = '{1'b1, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0042, 1'b1, 1'b1, 16'h0040};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0044, 1'b1, 1'b1, 16'h0042};

    reset = 1'b0; stall = 1'b0; jump = 1'b0; new_pc = 16'h0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 16'h0;
    w_rvalid = 1'b0; w_rdata = 16'h0;
    mem_ready = 1'b1; mem_lat = 1;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_req", imem_req, 1'b0);
    chk16("rst_addr", imem_addr, 16'h0000);
    chk16("rst_pc", pc_out, 16'h0000);
    chk16("rst_ir", ir_out, 16'h0000);
    chk16("rst_ipcp2", ipcp2, 16'h0000);
    chk1("rst_iv", if_valid, 1'b0);
    chk1("rst_w_req", w_req, 1'b0);
    chk16("rst_w_addr", w_addr, 16'hFFFE);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].stall, tbl[i].jump, tbl[i].new_pc);
      chk1($sformatf("vec%0d_req", i), cur_req, tbl[i].req);
      if (tbl[i].req) chk16($sformatf("vec%0d_addr", i), cur_addr, tbl[i].addr);
      chk1($sformatf("vec%0d_iv", i), if_valid, tbl[i].iv);
      if (tbl[i].chk_pc) chk16($sformatf("vec%0d_pc", i), pc_out, tbl[i].pc);
    end

    // Redirect while a slow response is outstanding: it must be drained and dropped.
    mem_lat = 3;
    cycle(1'b0, 1'b0, 16'h0);
    chk1("seqA_b2b_req", cur_req, 1'b1);
    cycle(1'b0, 1'b1, 16'h0040);
    chk1("seqA_jump_iv", if_valid, 1'b0);
    cycle(1'b0, 1'b0, 16'h0);
    chk1("seqA_drain_req", cur_req, 1'b0);
    cycle(1'b0, 1'b0, 16'h0);
    chk1("seqA_late_req", cur_req, 1'b0);
    chk1("seqA_late_discard", if_valid, 1'b0);
    mem_lat = 1;
    cycle(1'b0, 1'b0, 16'h0);
    chk1("seqA_redir_req", cur_req, 1'b1);
    chk16("seqA_redir_addr", cur_addr, 16'h0040);
    cycle(1'b0, 1'b0, 16'h0);
    chk16("seqA_redir_pc", pc_out, 16'h0040);

    for (int i = 0; i < 300; i++) begin
      mem_lat   = $urandom_range(1, 3);
      mem_ready = ($urandom_range(0, 3) != 0);
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
            {15'($urandom_range(0, 32767)), 1'b0});
    end

    mem_lat = 1; mem_ready = 1'b1;
    repeat (6) cycle(1'b0, 1'b0, 16'h0);

    // Memory not ready: the request and its address must hold.
    mem_ready = 1'b0;
    cycle(1'b0, 1'b0, 16'h0);
    a0 = exp_fetch;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 16'h0);
      chk1("notready_req", cur_req, 1'b1);
      chk16("notready_addr", cur_addr, a0);
    end
    mem_ready = 1'b1; mem_lat = 3;
    cycle(1'b0, 1'b0, 16'h0);

    // Asynchronous reset while a response is outstanding.
    reset = 1'b0;
    #1;
    chk1("async_rst_req", imem_req, 1'b0);
    chk16("async_rst_addr", imem_addr, 16'h0000);
    chk1("async_rst_iv", if_valid, 1'b0);
    chk16("async_rst_pc", pc_out, 16'h0000);
    chk16("async_rst_ir", ir_out, 16'h0000);
    chk16("async_rst_ipcp2", ipcp2, 16'h0000);
    clear_model();
    mem_lat = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    cycle(1'b0, 1'b0, 16'h0);
    chk1("rel_req", cur_req, 1'b1);
    chk16("rel_addr", cur_addr, 16'h0000);
    chk1("wrap_req0", cur_w_req, 1'b1);
    chk16("wrap_addr0", cur_w_addr, 16'hFFFE);
    cycle(1'b0, 1'b0, 16'h0);
    chk1("wrap_req1", cur_w_req, 1'b1);
    chk16("wrap_addr1", cur_w_addr, 16'h0000);
    chk1("wrap_iv", w_iv, 1'b1);
    chk16("wrap_pc", w_pc, 16'hFFFE);
    chk16("wrap_ir", w_ir, 16'h5A5B);
    chk16("wrap_ipcp2", w_ipcp2, 16'h0000);
    cycle(1'b0, 1'b0, 16'h0);
    chk16("wrap_pc2", w_pc, 16'h0000);
    chk16("wrap_ir2", w_ir, 16'hA5A5);
    chk16("wrap_ipcp2_2", w_ipcp2, 16'h0002);
    repeat (4) cycle(1'b0, 1'b0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
